conv_stream_driver: RTL and testbench

- Host-side counterpart to the conv_* stream blocks: the transmitter for their x input and the receiver for their y output.
- Streams a LENX-sample input vector from an internal load buffer on a valid/ready master port.
- Concurrently accepts LENX-LENF+1 result samples on a valid/ready slave port and stores them in a result buffer readable by the host.
- Sits between the host/testbench register interface and a conv_* instance.

---
 rtl/conv_stream_driver.sv | 148 ++++++++++++++
 tb/tb_conv_stream_driver.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_driver.sv
// Host-side stream driver for conv_* blocks: sends x from a load buffer and captures y into a result buffer.
// Optional macro STREAM_DRV_THROTTLE_EN adds a gap port that inserts idle cycles after each x transfer.
module conv_stream_driver #(
    parameter int WIDTH = 16,
    parameter int LENX  = 64,
    parameter int LENF  = 33,
    parameter int LOGX  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [LOGX-1:0]  load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
`ifdef STREAM_DRV_THROTTLE_EN
    input  logic [3:0]       gap,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] m_data_out_x,
    output logic             m_valid_x,
    input  logic             m_ready_x,
    input  logic [WIDTH-1:0] s_data_in_y,
    input  logic             s_valid_y,
    output logic             s_ready_y,
    input  logic [LOGX-1:0]  rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [LOGX:0]    y_count
);
    localparam int NUMY = LENX - LENF + 1;
    localparam logic [LOGX:0] TX_END = (LOGX+1)'(LENX);
    localparam logic [LOGX:0] RX_END = (LOGX+1)'(NUMY);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;

    logic [WIDTH-1:0] x_mem   [LENX];
    logic [WIDTH-1:0] res_mem [2**LOGX];

    logic [LOGX:0]    tx_cnt, rx_cnt, issue_cnt;
    logic [LOGX:0]    tx_cnt_n, rx_cnt_n;
    logic [WIDTH-1:0] rdq;
    logic             p1_vld;
    logic             tx_fire, rx_fire, out_load, issue, gap_ok, start_acc;

    assign start_acc = start && (state != RUN);
    assign tx_fire   = m_valid_x && m_ready_x;
    assign rx_fire   = s_valid_y && s_ready_y && (state == RUN);
    assign tx_cnt_n  = tx_cnt + {{LOGX{1'b0}}, tx_fire};
    assign rx_cnt_n  = rx_cnt + {{LOGX{1'b0}}, rx_fire};

`ifdef STREAM_DRV_THROTTLE_EN
    logic [3:0] gap_cnt;
    // gap_cnt==1 means the idle window ends this cycle, so the next sample may load now
    assign gap_ok = tx_fire ? (gap == 4'd0) : (gap_cnt <= 4'd1);

    always_ff @(posedge clk) begin
        if (reset || start_acc)
            gap_cnt <= '0;
        else if (state == RUN) begin
            if (tx_fire)
                gap_cnt <= gap;
            else if (gap_cnt != 4'd0)
                gap_cnt <= gap_cnt - 4'd1;
        end
    end
`else
    assign gap_ok = 1'b1;
`endif

    // Two-stage TX: buffer read register (p1) feeds the output register, keeping back-to-back flow
    assign out_load = (state == RUN) && p1_vld && (!m_valid_x || m_ready_x) && gap_ok;
    assign issue    = (state == RUN) && (issue_cnt < TX_END) && (!p1_vld || out_load);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (start) state_n = RUN;
            RUN:        if (tx_cnt_n == TX_END && rx_cnt_n == RX_END) state_n = DONE;
            default:    state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt       <= '0;
            rx_cnt       <= '0;
            issue_cnt    <= '0;
            p1_vld       <= 1'b0;
            m_valid_x    <= 1'b0;
            m_data_out_x <= '0;
            s_ready_y    <= 1'b0;
        end else begin
            if (start_acc) begin
                tx_cnt    <= '0;
                rx_cnt    <= '0;
                issue_cnt <= '0;
                p1_vld    <= 1'b0;
                m_valid_x <= 1'b0;
            end else if (state == RUN) begin
                tx_cnt <= tx_cnt_n;
                rx_cnt <= rx_cnt_n;
                if (issue)
                    issue_cnt <= issue_cnt + 1'b1;
                if (issue)
                    p1_vld <= 1'b1;
                else if (out_load)
                    p1_vld <= 1'b0;
                if (out_load) begin
                    m_valid_x    <= 1'b1;
                    m_data_out_x <= rdq;
                end else if (tx_fire)
                    m_valid_x <= 1'b0;
            end
            s_ready_y <= (state_n == RUN) && (start_acc || rx_cnt_n < RX_END);
        end
    end

    always_ff @(posedge clk) begin
        if (load_en && state != RUN)
            x_mem[load_addr] <= load_data;
        if (issue)
            rdq <= x_mem[issue_cnt[LOGX-1:0]];
        if (rx_fire)
            res_mem[rx_cnt[LOGX-1:0]] <= s_data_in_y;
    end

    always_ff @(posedge clk) begin
        if (reset)
            rd_data <= '0;
        else
            rd_data <= res_mem[rd_addr];
    end

    assign y_count = rx_cnt;
endmodule

// File: tb/tb_conv_stream_driver.sv
// Scoreboard bench for conv_stream_driver: directed x/y streams with queue-based monitors.
module tb_conv_stream_driver;
    localparam int WIDTH = 16, LENX = 64, LENF = 33, LOGX = 6, NUMY = LENX - LENF + 1;

    logic             clk = 0, reset = 1, load_en = 0, start = 0;
    logic [LOGX-1:0]  load_addr = '0, rd_addr = '0;
    logic [WIDTH-1:0] load_data = '0, s_data_in_y = '0;
    logic             m_ready_x = 0, s_valid_y = 0;
    logic [3:0]       gap = 4'd0;
    logic             busy, done, m_valid_x, s_ready_y;
    logic [WIDTH-1:0] m_data_out_x, rd_data;
    logic [LOGX:0]    y_count;

    conv_stream_driver #(.WIDTH(WIDTH), .LENX(LENX), .LENF(LENF), .LOGX(LOGX)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .start(start),
`ifdef STREAM_DRV_THROTTLE_EN
        .gap(gap),
`endif
        .busy(busy), .done(done), .m_data_out_x(m_data_out_x), .m_valid_x(m_valid_x),
        .m_ready_x(m_ready_x), .s_data_in_y(s_data_in_y), .s_valid_y(s_valid_y),
        .s_ready_y(s_ready_y), .rd_addr(rd_addr), .rd_data(rd_data), .y_count(y_count)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, tx_seen = 0;
    logic [WIDTH-1:0] x_q[$], y_q[$];
    logic             prev_hold = 0;
    logic [WIDTH-1:0] prev_data = '0;
    logic             pat_en = 0;
    logic [3:0]       pat = 4'b1001;
    int               pc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every handshake pops the scoreboard; stalled outputs must not change
    always @(negedge clk) begin
        if (reset) prev_hold = 0;
        else begin
            if (prev_hold) chk("tx_hold", {15'd0, m_valid_x, m_data_out_x}, {15'd0, 1'b1, prev_data});
            if (m_valid_x && m_ready_x) begin
                tx_seen++;
                if (x_q.size() == 0) chk("tx_extra", 32'(m_data_out_x), 32'hFFFF_FFFF);
                else chk("tx_data", 32'(m_data_out_x), 32'(x_q.pop_front()));
            end
            if (s_valid_y && s_ready_y) begin
                if (y_q.size() == 0) chk("rx_extra", 32'(s_data_in_y), 32'hFFFF_FFFF);
                else chk("rx_data", 32'(s_data_in_y), 32'(y_q.pop_front()));
            end
            prev_hold = m_valid_x && !m_ready_x;
            prev_data = m_data_out_x;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (pat_en) begin m_ready_x = pat[pc % 4]; pc++; end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic push_x(input logic [WIDTH-1:0] x5);
        for (int i = 0; i < LENX; i++) x_q.push_back((i == 5) ? x5 : WIDTH'(i + 1));
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic wait_tx(input int n);
        int c = 0;
        while (tx_seen < n && c < 2000) begin @(posedge clk); c++; end
        chk("tx_count", tx_seen, n);
    endtask

    task automatic drive_y(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1 s_valid_y = 1; s_data_in_y = WIDTH'(base + k);
        end
        @(posedge clk); #1 s_valid_y = 0;
    endtask

    task automatic finish_run(input int base);
        for (int k = 0; k < NUMY; k++) y_q.push_back(WIDTH'(base + k));
        drive_y(NUMY, base);
        @(negedge clk);
        chk("run_done", {30'd0, done, busy}, 32'b10);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_flags", {27'd0, busy, done, m_valid_x, s_ready_y, 1'b0}, 32'd0);
        chk("rst_vals", {m_data_out_x, rd_data}, 32'd0);
        chk("rst_ycnt", 32'(y_count), 32'd0);
        @(posedge clk); #1 reset = 0;

        for (int i = 0; i < LENX; i++) begin
            @(posedge clk); #1 load_en = 1; load_addr = LOGX'(i); load_data = WIDTH'(i + 1);
        end
        @(posedge clk); #1 load_en = 0;

        // Run 1: full-rate x, then 33 y with only 32 accepted
        m_ready_x = 1;
        push_x(16'd6);
        do_start();
        @(negedge clk); chk("lat_c0", {30'd0, busy, m_valid_x}, 32'b10);
        @(negedge clk); chk("lat_c1", 32'(m_valid_x), 32'd0);
        @(negedge clk); chk("lat_c2", 32'(m_valid_x), 32'd1);
        wait_tx(LENX);
        repeat (2) @(negedge clk);
        chk("tx_end_valid", 32'(m_valid_x), 32'd0);
        for (int k = 0; k < NUMY; k++) y_q.push_back(WIDTH'(100 + k));
        for (int k = 0; k < NUMY; k++) begin
            @(posedge clk); #1 s_valid_y = 1; s_data_in_y = WIDTH'(100 + k);
        end
        @(posedge clk); #1 s_data_in_y = 16'd132;
        @(negedge clk);
        chk("rx_full_ready", 32'(s_ready_y), 32'd0);
        chk("rx_full_ycnt", 32'(y_count), 32'd32);
        chk("rx_full_done", {30'd0, done, busy}, 32'b10);
        @(posedge clk); #1 s_valid_y = 0;
        @(negedge clk); chk("rx_no_extra", 32'(y_count), 32'd32);
        for (int a = 0; a < NUMY; a++) begin
            @(posedge clk); #1 rd_addr = LOGX'(a);
            @(posedge clk);
            @(negedge clk); chk("rd_data", 32'(rd_data), 32'(100 + a));
        end

        // Run 2: stalled x, ignored load and start during RUN
        tx_seen = 0;
        m_ready_x = 0;
        push_x(16'd6);
        pat_en = 1;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0; load_en = 1; load_addr = 6'd5; load_data = 16'h7FFF;
        @(posedge clk); #1 load_en = 0;
        wait_tx(20);
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        @(negedge clk); chk("busy_mid", 32'(busy), 32'd1);
        wait_tx(LENX);
        pat_en = 0; m_ready_x = 1;
        finish_run(200);

        // Run 3: load+start together in DONE, then reset mid-run
        tx_seen = 0;
        push_x(16'h7FFF);
        @(posedge clk); #1 load_en = 1; load_addr = 6'd5; load_data = 16'h7FFF; start = 1;
        @(posedge clk); #1 load_en = 0; start = 0;
        wait_tx(10);
        #1 reset = 1; m_ready_x = 0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst", {29'd0, m_valid_x, busy, done}, 32'd0);
        chk("mid_rst_ycnt", 32'(y_count), 32'd0);
        #1 reset = 0; m_ready_x = 1;
        x_q.delete();
        tx_seen = 0;
        push_x(16'h7FFF);
        do_start();
        wait_tx(LENX);
        finish_run(300);
        chk("q_x_empty", x_q.size(), 0);
        chk("q_y_empty", y_q.size(), 0);
        @(posedge clk); #1 rd_addr = 6'd31;
        @(posedge clk);
        @(negedge clk); chk("rd_last", 32'(rd_data), 32'd331);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
